// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family.
// Digit width, BCD limits, state codes and load sanitising.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A-F preset digits collapse to 9 so the count stays valid BCD.
  function automatic logic [3:0] bcd_sanitize(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the down-counter borrow chain.
// Decrements when dec_in is set, forwarding a borrow from 0.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_in,
  input  logic       load,
  input  logic [3:0] load_digit,
  output logic [3:0] digit,
  output logic       dec_out
);

  // Digit register: load wins over decrement; 0 borrows to 9.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_digit;
    end else if (dec_in) begin
      digit <= (digit == '0) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign dec_out = dec_in & (digit == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with optional wraparound.
// FSM, expiry/borrow pulses and zero detect around a digit chain.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WRAP   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                  enable,
  input  logic                  stop,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                  zero,
  output logic                  borrow,
  output logic                  done,
  output logic                  busy
);

  localparam int W = BCD_W * DIGITS;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   load_san;
  logic [DIGITS:0] chain;
  logic           wrap_on;
  logic           load_zero;
  logic           cnt_one;
  logic           dec_en;
  logic           done_nx;
  logic           borrow_nx;
  logic           start_done;
  state_t         start_st;

  assign wrap_on = (WRAP != 0);

  // Clamp every preset digit into 0..9 before it reaches the chain.
  always_comb begin
    load_san = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_san[i*BCD_W +: BCD_W] =
        bcd_sanitize(load_value[i*BCD_W +: BCD_W]);
    end
  end

  assign load_zero  = (load_san == '0);
  assign cnt_one    = (count == W'(1));
  assign start_done = load_zero & ~wrap_on;
  assign start_st   = start_done ? ST_DONE : ST_RUN;

  // Only an uncontested enable in RUN counts; no underflow unless wrapping.
  assign dec_en = (state == ST_RUN) & ~start & ~stop
                & enable & (wrap_on | ~zero);

  assign chain[0] = dec_en;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_down u_digit (
        .clk        (clk),
        .reset      (reset),
        .dec_in     (chain[g]),
        .load       (start),
        .load_digit (load_san[g*BCD_W +: BCD_W]),
        .digit      (count[g*BCD_W +: BCD_W]),
        .dec_out    (chain[g+1])
      );
    end
  endgenerate

  // A borrow leaving the top digit means 0..0 rolled to 9..9.
  assign borrow_nx = wrap_on & chain[DIGITS];

  // State and pulse registers.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      borrow <= 1'b0;
    end else begin
      state  <= state_nx;
      done   <= done_nx;
      borrow <= borrow_nx;
    end
  end

  // Next state: start > stop > enable; spare code behaves as IDLE.
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      ST_RUN: begin
        if (start) begin
          state_nx = start_st;
          done_nx  = start_done;
        end else if (stop) begin
          state_nx = ST_IDLE;
        end else if (enable & cnt_one & ~wrap_on) begin
          state_nx = ST_DONE;
          done_nx  = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nx = start_st;
          done_nx  = start_done;
        end else if (stop) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        if (start) begin
          state_nx = start_st;
          done_nx  = start_done;
        end
      end
    endcase
  end

  // Status outputs decoded from the current state and count.
  always_comb begin
    busy = (state == ST_RUN);
    zero = (count == '0);
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter, stop and wrap variants.
// Decimal-integer reference model; monitor pops after each edge.
module tb_bcd_down_counter;

  typedef struct packed {
    logic [15:0] count;
    logic        zero;
    logic        done;
    logic        borrow;
    logic        busy;
  } exp_t;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] load_value = '0;

  logic [15:0] c0, c1;
  logic        z0, z1, b0, b1, d0, d1, y0, y1;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mv [2];
  int   ms [2];
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(4), .WRAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start),
    .load_value(load_value), .enable(enable), .stop(stop),
    .count(c0), .zero(z0), .borrow(b0), .done(d0), .busy(y0)
  );

  bcd_down_counter #(.DIGITS(4), .WRAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start),
    .load_value(load_value), .enable(enable), .stop(stop),
    .count(c1), .zero(z1), .borrow(b1), .done(d1), .busy(y1)
  );

  function automatic int from_load(input logic [15:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int val);
    logic [15:0] r;
    int v;
    v = val;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit s, input bit p,
                            input bit e, input logic [15:0] lv);
    exp_t x;
    bit   dn;
    bit   br;
    for (int w = 0; w < 2; w++) begin
      dn = 1'b0;
      br = 1'b0;
      if (s) begin
        mv[w] = from_load(lv);
        if (mv[w] == 0 && w == 0) begin
          ms[w] = M_DONE;
          dn = 1'b1;
        end else begin
          ms[w] = M_RUN;
        end
      end else if (ms[w] == M_RUN) begin
        if (p) begin
          ms[w] = M_IDLE;
        end else if (e) begin
          if (mv[w] == 0) begin
            if (w == 1) begin
              mv[w] = 9999;
              br = 1'b1;
            end
          end else begin
            mv[w] = mv[w] - 1;
            if (mv[w] == 0 && w == 0) begin
              ms[w] = M_DONE;
              dn = 1'b1;
            end
          end
        end
      end else if (ms[w] == M_DONE && p) begin
        ms[w] = M_IDLE;
      end
      x.count  = to_bcd(mv[w]);
      x.zero   = (mv[w] == 0);
      x.done   = dn;
      x.borrow = br;
      x.busy   = (ms[w] == M_RUN);
      if (w == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
  endtask

  task automatic cyc(input bit s, input bit p,
                     input bit e, input logic [15:0] lv);
    @(posedge clk);
    #1;
    start = s;
    stop = p;
    enable = e;
    load_value = lv;
    model_step(s, p, e, lv);
  endtask

  task automatic chk_rst(input int w, input exp_t got);
    exp_t want;
    want = '{count: 16'h0, zero: 1'b1, done: 1'b0,
             borrow: 1'b0, busy: 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL reset_wrap%0d got=%h want=%h", w, got, want);
    end
  endtask

  task automatic reset_chk();
    @(posedge clk);
    #1;
    start = 0;
    stop = 0;
    enable = 0;
    load_value = '0;
    reset = 1'b1;
    #1;
    chk_rst(0, {c0, z0, d0, b0, y0});
    chk_rst(1, {c1, z1, d1, b1, y1});
    #1;
    reset = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mv[w] = 0;
      ms[w] = M_IDLE;
    end
    model_step(0, 0, 0, 16'h0);
  endtask

  initial begin : monitor
    exp_t got;
    exp_t want;
    forever begin
      @(negedge clk);
      #2;
      if (q0.size() > 0) begin
        want = q0.pop_front();
        got = {c0, z0, d0, b0, y0};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL edge_wrap0 t=%0t got=%h want=%h",
                   $time, got, want);
        end
      end
      if (q1.size() > 0) begin
        want = q1.pop_front();
        got = {c1, z1, d1, b1, y1};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL edge_wrap1 t=%0t got=%h want=%h",
                   $time, got, want);
        end
      end
    end
  end

  initial begin : driver
    bit          s, p, e;
    logic [15:0] lv;
    mv[0] = 0; mv[1] = 0;
    ms[0] = M_IDLE; ms[1] = M_IDLE;
    reset_chk();

    cyc(1, 0, 1, 16'h0012);
    repeat (17) cyc(0, 0, 1, 16'h0);

    cyc(1, 0, 0, 16'h1000);
    cyc(0, 0, 1, 16'h0);
    cyc(1, 0, 0, 16'h0100);
    cyc(0, 0, 1, 16'h0);

    cyc(1, 0, 0, 16'h0002);
    repeat (3) cyc(0, 0, 1, 16'h0);

    cyc(1, 0, 0, 16'h0005);
    repeat (3) cyc(0, 0, 0, 16'h0);
    cyc(1, 1, 1, 16'h0020);
    cyc(0, 1, 0, 16'h0);
    cyc(0, 0, 1, 16'h0);

    cyc(1, 0, 0, 16'h00AF);
    cyc(1, 0, 0, 16'h0000);
    cyc(0, 0, 1, 16'h0);
    cyc(0, 1, 0, 16'h0);

    cyc(1, 0, 0, 16'h0347);
    cyc(0, 0, 0, 16'h0);
    reset_chk();

    repeat (600) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_chk();
      end else begin
        s = ($urandom_range(0, 15) == 0);
        p = ($urandom_range(0, 31) == 0);
        e = ($urandom_range(0, 3) != 0);
        lv = 16'($urandom);
        if ($urandom_range(0, 1) == 1) lv[15:8] = 8'h00;
        cyc(s, p, e, lv);
      end
    end

    @(posedge clk);
    start = 0;
    stop = 0;
    enable = 0;
    repeat (3) @(negedge clk);
    #3;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got=%0d/%0d want=0/0",
               q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous multi-digit BCD down-counter/countdown timer; the counting-down counterpart to the team's BCD up (ripple) counter.
- Loads a BCD preset, decrements one count per enabled clock, and flags expiry.
- Used as a timeout/interval timer, or as a digit source for display logic, in the ch6 counter family.

Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
- WRAP, 0, 0 = stop at zero and go to DONE; 1 = roll 0…0 -> 9…9 and keep running.

Ports:
- clk  input  1  clock; all state updates on the falling edge of clk.
- reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
- start  input  1  load load_value and begin counting (sampled on the clk edge).
- load_value  input  4*DIGITS  BCD preset, digit 0 in bits [3:0].
- enable  input  1  count qualifier; a decrement occurs only on edges where enable=1 in RUN.
- stop  input  1  abort the count and return to IDLE, holding the current count.
- count  output  4*DIGITS  current BCD value.
- zero  output  1  combinational: count == 0.
- borrow  output  1  one-cycle pulse on wrap 0…0 -> 9…9 (WRAP=1 only).
- done  output  1  one-cycle pulse on the edge that enters DONE.
- busy  output  1  high in RUN.

Behaviour:
- Reset values: count=0, state=IDLE, done=0, borrow=0, busy=0. zero=1 follows from count=0.
- States: IDLE, RUN, DONE. Encoded in 2 bits; the unused code decodes to IDLE.
- IDLE:
  - start=1 -> count<=sanitised load_value, go to RUN.
  - If the sanitised value is 0 and WRAP=0, go directly to DONE and pulse done.
- RUN, priority order:
  - start reloads (restart) and stays in RUN.
  - else stop -> IDLE, count held.
  - else enable -> decrement.
  - else hold.
- Decrement:
  - Digit-serial borrow chain. Digit i decrements if all lower digits are 0.
  - A digit at 0 that decrements becomes 9 and propagates the borrow; otherwise it becomes d-1.
  - Single-cycle latency: the new count is visible after the same edge.
- Expiry, WRAP=0:
  - The edge that takes count from 1 to 0 moves to DONE.
  - done=1 for exactly that cycle; count then holds 0.
- Expiry, WRAP=1:
  - Never enters DONE.
  - Count 0 with enable -> all 9s, borrow=1 for one cycle; done is never asserted.
  - The count 1->0 edge pulses nothing; zero simply goes high.
- DONE: holds count=0. start -> reload and go to RUN (same rules as IDLE). stop -> IDLE.
- Sanitising: any load digit >9 (A–F) loads as 9. The counter never holds a non-BCD digit.
- Simultaneous events:
  - start has priority over stop, and stop over enable.
  - start in RUN with enable=1 loads and does not decrement that edge.
- Reset mid-count: count clears at once (asynchronous), done/borrow are not pulsed, state goes to IDLE.
- done and borrow are registered, never combinational glitches.

Decomposition:
- Shared package (bcd_pkg):
  - BCD_W=4 and BCD_MAX=4'd9.
  - State encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2).
  - Digit sanitise function (clamp >9 to 9).
- Sub-module bcd_digit_down: one 4-bit digit register with inputs dec_in/load/load_digit and outputs digit/dec_out (dec_out = dec_in & digit==0).
  - Instantiated DIGITS times in a generate chain.
  - The top-level holds the FSM, done/borrow registers and the zero reduction.

Test Plan:
- Reset: assert reset between clk edges, mid-RUN with count=0x0347 -> count=0x0000, zero=1, busy=0 immediately, with no done pulse.
- Load and count (DIGITS=4, WRAP=0): start with load_value=0x0012, enable held 1.
  - count sequence 0012, 0011, 0010, 0009, … 0001, 0000.
  - done=1 for exactly one cycle on the 0001->0000 edge.
  - state DONE, count held at 0000 for 5 further edges.
- Borrow chain: load 0x1000 and one enabled edge -> 0x0999; load 0x0100 -> 0x0099.
- Wrap (WRAP=1): load 0x0002 and 3 enabled edges -> 0002, 0001, 0000, 9999; borrow=1 only on the 0000->9999 edge; done never asserted.
- Enable gating and priority:
  - From 0x0005 in RUN, enable=0 for 3 edges -> holds 0005.
  - start=1, stop=1, enable=1 together with load_value=0x0020 -> count=0020, still RUN.
  - stop alone -> IDLE, count 0020 held, busy=0.
- Sanitise and zero-load:
  - load_value=0x00AF -> count=0x0099.
  - load_value=0x0000 with WRAP=0 -> done pulses on the load edge and state is DONE.
